// File: rtl/spectrum_bar_scanner_pkg.sv
// spectrum_pkg: shared types and helpers for the spectrum bar scanner.
//   NBINS / LVL_W : bin count and bits per bin level
//   ROWS          : LED rows per column (one per non-zero level)
//   state_e       : scanner state (IDLE / BLANK / DRIVE)
//   get_bin       : extract bin idx from a packed level word (bin0 in LSBs)
//   bar_pattern   : row drive for a column given live level L and peak P
package spectrum_pkg;

  localparam int unsigned NBINS = 16;
  localparam int unsigned LVL_W = 2;
  localparam int unsigned ROWS  = (1 << LVL_W) - 1;

  typedef logic [LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_e;

  function automatic lvl_t get_bin(input logic [NBINS*LVL_W-1:0] word,
                                   input int unsigned            idx);
    return word[idx*LVL_W +: LVL_W];
  endfunction

  // Row k lights for the live bar (L > k) plus a single peak marker at row P-1.
  function automatic logic [ROWS-1:0] bar_pattern(input lvl_t l, input lvl_t p);
    logic [ROWS-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < ROWS; k++) begin
      r[k] = (l > lvl_t'(k)) || ((p != '0) && (p == lvl_t'(k + 1)));
    end
    return r;
  endfunction

endpackage

// File: rtl/spectrum_bar_scanner_bin_peak_hold.sv
// bin_peak_hold: per-bin peak register with hold-then-decay timing.
// Only built when SPECTRUM_PEAK_HOLD_EN is defined; otherwise the scanner
// uses the live level as the peak and this module does not exist.
//   clk, rst_n : clock, async active-low reset
//   update     : frame boundary with a valid snapshot
//   clear      : frame boundary without a valid snapshot (go idle)
//   lvl_in     : new level for this bin
//   peak       : held peak level
`ifdef SPECTRUM_PEAK_HOLD_EN
module bin_peak_hold
  import spectrum_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update,
  input  logic clear,
  input  lvl_t lvl_in,
  output lvl_t peak
);

  localparam int unsigned    HW          = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0]  HOLD_RELOAD = HW'(HOLD_FRAMES);

  lvl_t          peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (clear) begin
      peak_d = '0;
      hold_d = '0;
    end else if (update) begin
      if (lvl_in >= peak_q) begin
        peak_d = lvl_in;
        hold_d = HOLD_RELOAD;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else begin
        // lvl_in < peak_q guarantees peak_q > 0, so no underflow here
        peak_d = peak_q - lvl_t'(1);
        hold_d = HOLD_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign peak = peak_q;

endmodule
`endif

// File: rtl/spectrum_bar_scanner.sv
// spectrum_bar_scanner: latches one 16-bin level snapshot per display frame
// and time-multiplexes it onto a 16-column x 3-row LED bar matrix.
// Optional peak-hold with timed decay: define SPECTRUM_PEAK_HOLD_EN.
//   clk, rst_n  : clock, async active-low reset
//   raise_valid : snapshot on raise_data is meaningful (sampled at frame boundary)
//   raise_data  : packed levels, bin i in bits[2i+1:2i]
//   col_n       : one-hot active-low column select (registered)
//   row_on      : active-high row drive (registered)
//   frame_tick  : one-cycle pulse in the first cycle of column 0 (registered)
//   peak_data   : packed held-peak levels (live levels without peak-hold)
module spectrum_bar_scanner
  import spectrum_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1024,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     raise_valid,
  input  logic [NBINS*LVL_W-1:0]   raise_data,
  output logic [NBINS-1:0]         col_n,
  output logic [ROWS-1:0]          row_on,
  output logic                     frame_tick,
  output logic [NBINS*LVL_W-1:0]   peak_data
);

  localparam int unsigned         DIV_W   = $clog2(SCAN_DIV);
  localparam int unsigned         COL_W   = $clog2(NBINS);
  localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]    COL_MAX = COL_W'(NBINS - 1);

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [COL_W-1:0]         col_cnt_q, col_cnt_d;
  logic [NBINS*LVL_W-1:0]   lvl_q, lvl_d;
  logic [NBINS-1:0]         col_n_q, col_n_d;
  logic [ROWS-1:0]          row_on_q, row_on_d;
  logic                     frame_tick_q, frame_tick_d;
  logic [NBINS*LVL_W-1:0]   peak_w;
  logic                     div_wrap, fb;

`ifdef SPECTRUM_PEAK_HOLD_EN
  for (genvar i = 0; i < NBINS; i++) begin : g_bin
    bin_peak_hold #(
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_peak (
      .clk   (clk),
      .rst_n (rst_n),
      .update(fb && raise_valid),
      .clear (fb && !raise_valid),
      .lvl_in(get_bin(raise_data, i)),
      .peak  (peak_w[i*LVL_W +: LVL_W])
    );
  end
`else
  assign peak_w = lvl_q;
`endif

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_MAX);
    fb        = div_wrap && (col_cnt_q == COL_MAX);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    col_cnt_d = col_cnt_q;
    if (div_wrap) begin
      col_cnt_d = (col_cnt_q == COL_MAX) ? '0 : col_cnt_q + COL_W'(1);
    end

    // state_q always describes the counter values of the same cycle, so the
    // BLANK/DRIVE choice looks at the next div_cnt
    state_d = state_q;
    if (fb && !raise_valid) begin
      state_d = IDLE;
    end else if (fb || (state_q != IDLE)) begin
      state_d = (div_cnt_d < DIV_W'(BLANK_CYC)) ? BLANK : DRIVE;
    end

    lvl_d = lvl_q;
    if (fb) begin
      lvl_d = raise_valid ? raise_data : '0;
    end

    // Column scan keeps running in IDLE so frame_tick keeps its cadence
    col_n_d      = ~(NBINS'(1) << col_cnt_q);
    frame_tick_d = (div_cnt_q == '0) && (col_cnt_q == '0);
    row_on_d     = '0;
    if ((state_q == DRIVE) && !(fb && !raise_valid)) begin
      row_on_d = bar_pattern(get_bin(lvl_q, 32'(col_cnt_q)),
                             get_bin(peak_w, 32'(col_cnt_q)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      col_cnt_q    <= '0;
      lvl_q        <= '0;
      col_n_q      <= '1;
      row_on_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      col_cnt_q    <= col_cnt_d;
      lvl_q        <= lvl_d;
      col_n_q      <= col_n_d;
      row_on_q     <= row_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign col_n      = col_n_q;
  assign row_on     = row_on_q;
  assign frame_tick = frame_tick_q;
  assign peak_data  = peak_w;

endmodule

// File: tb/tb_spectrum_bar_scanner.sv
// tb_spectrum_bar_scanner: self-checking bench for spectrum_bar_scanner with
// SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2. A frame-level reference model
// (levels, peaks, hold counts as plain integers) predicts every output cycle.
// Define SPECTRUM_PEAK_HOLD_EN for both RTL and bench to cover peak-hold.
module tb_spectrum_bar_scanner;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int HF = 2;
  localparam int FR = SD * 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        raise_valid = 1'b0;
  logic [31:0] raise_data = '0;
  logic [15:0] col_n;
  logic [2:0]  row_on;
  logic        frame_tick;
  logic [31:0] peak_data;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          n = 0;
  bit          active = 0;
  int          ml[16];
  int          mp[16];
  int          mh[16];
  logic [51:0] exp_vec;

  spectrum_bar_scanner #(
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raise_valid(raise_valid),
    .raise_data (raise_data),
    .col_n      (col_n),
    .row_on     (row_on),
    .frame_tick (frame_tick),
    .peak_data  (peak_data)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] bar_model(input int l, input int p);
    int v;
    v = (1 << l) - 1;
    if (p > 0) v = v | (1 << (p - 1));
    return 3'(v);
  endfunction

  task automatic model_clear();
    active = 0;
    for (int b = 0; b < 16; b++) begin
      ml[b] = 0;
      mp[b] = 0;
      mh[b] = 0;
    end
  endtask

  task automatic model_frame();
    if (!raise_valid) begin
      model_clear();
    end else begin
      active = 1;
      for (int b = 0; b < 16; b++) begin
        int nv;
        nv = int'((raise_data >> (2 * b)) & 32'd3);
        ml[b] = nv;
`ifdef SPECTRUM_PEAK_HOLD_EN
        if (nv >= mp[b]) begin
          mp[b] = nv;
          mh[b] = HF;
        end else if (mh[b] > 0) begin
          mh[b] = mh[b] - 1;
        end else begin
          mp[b] = mp[b] - 1;
          mh[b] = HF;
        end
`else
        mp[b] = nv;
`endif
      end
    end
  endtask

  // Predict outputs produced by the next edge, apply the edge, sample at +1.
  task automatic tick();
    int          div, col;
    bit          fbm;
    logic [2:0]  r;
    logic [31:0] pk;
    logic [15:0] cn;
    div = n % SD;
    col = (n / SD) % 16;
    fbm = (n % FR) == FR - 1;
    cn  = ~(16'h1 << col);
    r   = '0;
    if (active && div >= BC && !(fbm && !raise_valid)) r = bar_model(ml[col], mp[col]);
    if (fbm) model_frame();
    pk = '0;
    for (int b = 0; b < 16; b++) pk[2*b +: 2] = 2'(mp[b]);
    exp_vec = {cn, r, ((n % FR) == 0), pk};
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic test_reset();
    raise_valid = 1'b0;
    raise_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (col_n !== 16'hFFFF) begin miscompares++; $display("FAIL reset_col_n got %h exp ffff", col_n); end
    vectors++;
    if (row_on !== 3'b000) begin miscompares++; $display("FAIL reset_row_on got %b exp 000", row_on); end
    vectors++;
    if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
    vectors++;
    if (peak_data !== 32'h0) begin miscompares++; $display("FAIL reset_peak_data got %h exp 0", peak_data); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL idle_scan n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
  endtask

  task automatic test_capture();
    int want[4] = '{0, 1, 3, 7};
    int k, c;
    raise_valid = 1'b1;
    raise_data  = 32'hE4E4_E4E4;
    k = FR - (n % FR);
    for (int i = 0; i < k; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL capture_pre n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
    vectors++;
    if (peak_data !== 32'hE4E4_E4E4) begin miscompares++; $display("FAIL capture_peak got %h exp e4e4e4e4", peak_data); end
    for (int i = 0; i < FR; i++) begin
      tick();
      c = (n - 1) % FR;
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL capture_scan n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
      if (c % SD == 4 && c / SD < 4) begin
        vectors++;
        if (row_on !== 3'(want[c / SD])) begin
          miscompares++;
          $display("FAIL capture_bar col=%0d got %b exp %b", c / SD, row_on, 3'(want[c / SD]));
        end
      end
    end
  endtask

  task automatic test_no_tearing();
    int ticks;
    ticks = 0;
    raise_valid = 1'b1;
    raise_data  = 32'hE4E4_E4E4;
    for (int i = 0; i < FR; i++) begin
      if ((n % FR) == 5 * SD + 4) raise_data = 32'h0;
      tick();
      if (frame_tick === 1'b1) ticks++;
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL no_tearing n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
    vectors++;
    if (ticks !== 1) begin miscompares++; $display("FAIL frame_tick_count got %0d exp 1", ticks); end
  endtask

  task automatic test_peak_decay();
`ifdef SPECTRUM_PEAK_HOLD_EN
    int want[10] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
`else
    int want[10] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    int k;
    raise_valid = 1'b1;
    raise_data  = 32'h0000_0003;
    for (int f = 0; f < 10; f++) begin
      k = FR - (n % FR);
      for (int i = 0; i < k; i++) begin
        tick();
        vectors++;
        if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
          miscompares++;
          $display("FAIL peak_decay n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
        end
      end
      vectors++;
      if (int'(peak_data[1:0]) !== want[f]) begin
        miscompares++;
        $display("FAIL peak_bin0 frame=%0d got %0d exp %0d", f, peak_data[1:0], want[f]);
      end
      raise_data = 32'h0;
    end
  endtask

  task automatic test_valid_drop();
    int k;
    logic [31:0] d;
    raise_valid = 1'b0;
    k = FR - (n % FR);
    for (int i = 0; i < k; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL drop_pre n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
    vectors++;
    if (row_on !== 3'b000) begin miscompares++; $display("FAIL drop_row_on got %b exp 000", row_on); end
    vectors++;
    if (peak_data !== 32'h0) begin miscompares++; $display("FAIL drop_peak got %h exp 0", peak_data); end
    d = $urandom;
    raise_valid = 1'b1;
    raise_data  = d;
    for (int i = 0; i < FR; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL drop_resume n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
    vectors++;
    if (peak_data !== d) begin miscompares++; $display("FAIL resume_peak got %h exp %h", peak_data, d); end
    for (int i = 0; i < FR; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL drop_shown n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    int k, mid;
    for (int f = 0; f < 8; f++) begin
      raise_valid = ($urandom_range(0, 3) != 0);
      raise_data  = $urandom;
      k   = FR - (n % FR);
      mid = $urandom_range(0, k - 1);
      for (int i = 0; i < k; i++) begin
        if (i == mid) raise_data = $urandom;
        tick();
        vectors++;
        if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
          miscompares++;
          $display("FAIL random n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    raise_valid = 1'b1;
    raise_data  = $urandom | 32'h0000_C000;
    k = FR - (n % FR);
    for (int i = 0; i < k + 7 * SD + 5; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL pre_reset n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
    vectors++;
    if (row_on !== 3'b111) begin miscompares++; $display("FAIL col7_drive got %b exp 111", row_on); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (col_n !== 16'hFFFF) begin miscompares++; $display("FAIL async_col_n got %h exp ffff", col_n); end
    vectors++;
    if (row_on !== 3'b000) begin miscompares++; $display("FAIL async_row_on got %b exp 000", row_on); end
    vectors++;
    if (peak_data !== 32'h0) begin miscompares++; $display("FAIL async_peak got %h exp 0", peak_data); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n = 0;
    tick();
    vectors++;
    if (col_n !== 16'hFFFE) begin miscompares++; $display("FAIL restart_col_n got %h exp fffe", col_n); end
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      vectors++;
      if ({col_n, row_on, frame_tick, peak_data} !== exp_vec) begin
        miscompares++;
        $display("FAIL post_reset n=%0d got %h exp %h", n - 1, {col_n, row_on, frame_tick, peak_data}, exp_vec);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_capture();
    test_no_tearing();
    test_peak_decay();
    test_valid_drop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
